// File: rtl/io_dig_display.sv
// rtl/io_dig_display.sv - 8-digit multiplexed 7-segment display responder (optional blink: DIG_BLINK_EN)
module io_dig_display #(
    parameter int          SCAN_DIV     = 20000,
    parameter int          BLINK_ROUNDS = 64,
    parameter logic [31:0] ADDR_DATA    = 32'hFFFF_F000,
    parameter logic [31:0] ADDR_CTRL    = 32'hFFFF_F004
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [7:0]  dig_en,
    output logic [7:0]  seg_n
);

    localparam int             CNT_W    = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [31:0]      data_reg;
    logic [31:0]      ctrl_reg;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic             slot_end;
    logic             blink_off;
    logic             ctrl_unused;
    logic [7:0]       en_mask;
    logic [7:0]       dp_mask;
    logic [3:0]       nibble;
    logic [7:0]       dig_nxt;
    logic [7:0]       seg_nxt;

    // Active-low glyphs {G,F,E,D,C,B,A} for one hex nibble
    function automatic logic [6:0] hex_glyph(input logic [3:0] v);
        case (v)
            4'h0:    hex_glyph = 7'h40;
            4'h1:    hex_glyph = 7'h79;
            4'h2:    hex_glyph = 7'h24;
            4'h3:    hex_glyph = 7'h30;
            4'h4:    hex_glyph = 7'h19;
            4'h5:    hex_glyph = 7'h12;
            4'h6:    hex_glyph = 7'h02;
            4'h7:    hex_glyph = 7'h78;
            4'h8:    hex_glyph = 7'h00;
            4'h9:    hex_glyph = 7'h10;
            4'hA:    hex_glyph = 7'h08;
            4'hB:    hex_glyph = 7'h03;
            4'hC:    hex_glyph = 7'h46;
            4'hD:    hex_glyph = 7'h21;
            4'hE:    hex_glyph = 7'h06;
            default: hex_glyph = 7'h0E;
        endcase
    endfunction

    assign slot_end = (cnt == CNT_LAST);
    assign en_mask  = ctrl_reg[7:0];
    assign dp_mask  = ctrl_reg[23:16];
    assign nibble   = data_reg[{idx, 2'b00} +: 4];

    // CPU stores into the two write-only registers; other addresses are ignored
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_reg <= 32'h0;
            ctrl_reg <= 32'h0000_00FF;
        end else if (we) begin
            if (addr == ADDR_DATA) begin
                data_reg <= wdata;
            end else if (addr == ADDR_CTRL) begin
                ctrl_reg <= wdata;
            end
        end
    end

    // Slot counter; the last cycle of each slot is the blank and advances the digit
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
            idx <= 3'd0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= idx + 3'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

`ifdef DIG_BLINK_EN
    localparam int               RND_W    = (BLINK_ROUNDS > 1) ? $clog2(BLINK_ROUNDS) : 1;
    localparam logic [RND_W-1:0] RND_LAST = RND_W'(BLINK_ROUNDS - 1);

    logic [RND_W-1:0] round_cnt;
    logic             blink_phase;
    logic             round_end;
    logic [7:0]       blink_mask;

    assign round_end   = slot_end && (idx == 3'd7);
    assign blink_mask  = ctrl_reg[15:8];
    assign blink_off   = blink_phase & blink_mask[idx];
    assign ctrl_unused = ^ctrl_reg[31:24];

    // Count whole scan rounds and flip the blink phase every BLINK_ROUNDS of them
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            round_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (round_end) begin
            if (round_cnt == RND_LAST) begin
                round_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                round_cnt <= round_cnt + 1'b1;
            end
        end
    end
`else
    assign blink_off   = 1'b0;
    assign ctrl_unused = ^{ctrl_reg[31:24], ctrl_reg[15:8]};
`endif

    // Next display drive: dark on the blank cycle, for masked digits and while blinked off
    always_comb begin
        dig_nxt = 8'hFF;
        seg_nxt = 8'hFF;
        if (!slot_end && en_mask[idx] && !blink_off) begin
            dig_nxt = ~(8'h01 << idx);
            seg_nxt = {~dp_mask[idx], hex_glyph(nibble)};
        end
    end

    // Registered outputs so the pads never see combinational glitches
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dig_en <= 8'hFF;
            seg_n  <= 8'hFF;
        end else begin
            dig_en <= dig_nxt;
            seg_n  <= seg_nxt;
        end
    end

endmodule

// File: doc/io_dig_display.md
Name: io_dig_display

Overview:
- Memory-mapped responder for the 8-digit 7-segment display.
- Sits on the bridge's digit port, which carries the clock, reset, address, write-enable and write-data to the display.
- Accepts CPU store writes into a data register and a control register.
- Time-multiplexes 8 hex digits onto the shared active-low segment bus, with a one-cycle anti-ghosting blank between digits.

Parameters:
- SCAN_DIV, 20000: cpu_clk cycles per digit slot, including the 1 blank cycle; legal range ≥2.
- BLINK_ROUNDS, 64: full 8-digit scan rounds per blink half-period; used only with DIG_BLINK_EN.
- ADDR_DATA, 32'hFFFF_F000: address of the data register.
- ADDR_CTRL, 32'hFFFF_F004: address of the control register.

Ports:
- clk  input  1  cpu_clk from the bridge.
- rstn  input  1  asynchronous active-low reset.
- addr  input  32  bus address from the bridge.
- we  input  1  write strobe, one cycle per store.
- wdata  input  32  store data.
- dig_en  output  8  digit enables, active-low; bit i selects digit i, and digit 0 is the rightmost.
- seg_n  output  8  segments, active-low, ordered {DP,G,F,E,D,C,B,A}; the top level fans this out to DN_*0/DN_*1.

Behaviour:
- Clock and reset: one clock, clk. Reset rstn is asynchronous assert and active-low. All state and outputs are flops cleared by rstn.
- Reset values:
  - data_reg = 0.
  - ctrl_reg = 32'h0000_00FF: all digits enabled, no DP, no blink.
  - scan counter = 0; digit index = 0.
  - dig_en = 8'hFF and seg_n = 8'hFF (all dark).
- Register writes:
  - At a rising edge with we=1 and addr==ADDR_DATA: data_reg <= wdata.
  - At a rising edge with we=1 and addr==ADDR_CTRL: ctrl_reg <= wdata.
  - Any other address: ignored.
- Control fields:
  - ctrl[7:0]: per-digit enable mask (1 = shown).
  - ctrl[15:8]: blink mask.
  - ctrl[23:16]: decimal-point mask (1 = DP lit).
  - Other bits: stored but unused.
- The block is write-only: there is no read path to the bridge.
- Scan counter:
  - cnt runs 0..SCAN_DIV-1, then wraps to 0.
  - When cnt==SCAN_DIV-1, the digit index increments mod 8 (7 wraps to 0).
- Output register, updated every edge from the current index i, cnt, data_reg and ctrl_reg:
  - Blank cycle (cnt==SCAN_DIV-1): dig_en=8'hFF, seg_n=8'hFF.
  - Digit i disabled (ctrl[i]==0): dig_en=8'hFF, seg_n=8'hFF.
  - Otherwise: dig_en = ~(8'b1<<i). seg_n[6:0] = active-low hex pattern of data_reg[4i+3:4i] for 0–F. A–F use the standard glyphs A b C d E F. seg_n[7] = ~ctrl[16+i].
- Latency:
  - A write at edge N appears on seg_n at edge N+1 if digit i is currently being driven.
  - Otherwise it appears when the scan reaches that digit.
- Simultaneous events:
  - A write coincident with a digit change: the new data_reg value is used starting at edge N+1. No partial nibble is ever shown.
- Reset mid-scan: outputs go dark immediately (asynchronously). The scan restarts at digit 0, cnt=0, after rstn deasserts.
- Full-round timing: 8*SCAN_DIV cycles. Each digit is lit for SCAN_DIV-1 cycles per round.

Optional Feature:
- Macro: DIG_BLINK_EN.
- With the macro defined:
  - A round counter counts completed 8-digit rounds (increment when index 7→0).
  - When the count reaches BLINK_ROUNDS-1, it wraps and blink_phase toggles. blink_phase resets to 0.
  - While blink_phase==1, any digit with ctrl[8+i]==1 is driven dark (dig_en=8'hFF, seg_n=8'hFF) during its slot.
- Without the macro: ctrl[15:8] are stored but have no effect; no round counter or blink_phase logic is synthesized.

Test Plan:
1. Reset: rstn=0 at mid-scan -> dig_en=8'hFF and seg_n=8'hFF asynchronously. After release with SCAN_DIV=4: dig_en=8'hFE from the first edge, with index 0.
2. SCAN_DIV=4, write data 32'h1234_ABCD to 32'hFFFF_F000.
   - Digit 0 shows seg_n=8'hA1 ("d").
   - Digit 3 shows 8'h88 ("A").
   - Digit 7 shows 8'hF9 ("1").
   - Each slot is 3 lit cycles plus 1 cycle with dig_en=8'hFF.
   - Index wraps 7->0 after 32 cycles.
3. Write ctrl 32'h0001_000F -> digits 4–7 dark during their slots. Digit 0 has seg_n[7]=0 (DP lit).
4. Write to 32'hFFFF_F008 with wdata=32'hFFFF_FFFF -> no register change and display unchanged.
5. Write data while digit 2 is driven -> seg_n changes exactly one edge after the write edge; dig_en is unchanged.
6. DIG_BLINK_EN defined, BLINK_ROUNDS=2, ctrl=32'h0000_01FF:
   - Digit 0 is dark in rounds 2–3, lit in rounds 4–5, and so on.
   - Other digits are unaffected.
   - Without the macro, digit 0 is always lit.
